fwd_hazard_unit: RTL and testbench

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_pkg.sv | 14 +
 rtl/fwd_scoreboard.sv | 48 ++++
 rtl/fwd_hazard_unit.sv | 111 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared constants and helpers for the forwarding / hazard-detection unit.
package fwd_pkg;

    localparam int REG_IDX_W     = 5;
    localparam int NUM_ARCH_REGS = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // Width of a forwarding select: 0 = register file, j+1 = stage j.
    function automatic int fwd_sel_w(input int num_fwd);
        return (num_fwd < 1) ? 1 : $clog2(num_fwd + 1);
    endfunction

endpackage

// File: rtl/fwd_scoreboard.sv
// Pending-write scoreboard for long-latency ops; blocks WAW re-issue on a pending rd.
module fwd_scoreboard
    import fwd_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lat_issue,
    input  reg_idx_t                 lat_rd,
    input  logic                     lat_done,
    input  reg_idx_t                 lat_done_rd,
    output logic [NUM_ARCH_REGS-1:0] pending,
    output logic                     issue_stall
);

    // Register 0 can never be pending.
    localparam logic [NUM_ARCH_REGS-1:0] WRITABLE = {{(NUM_ARCH_REGS-1){1'b1}}, 1'b0};

    logic [NUM_ARCH_REGS-1:0] pend_q;
    logic [NUM_ARCH_REGS-1:0] set_vec;
    logic [NUM_ARCH_REGS-1:0] clr_vec;

    assign pending = pend_q;

    // A completion on the same rd in the same cycle frees the slot for the new issue.
    assign issue_stall = lat_issue && pend_q[lat_rd] &&
                         !(lat_done && (lat_done_rd == lat_rd));

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (lat_issue && !issue_stall && (lat_rd != '0)) begin
            set_vec[lat_rd] = 1'b1;
        end
        if (lat_done) begin
            clr_vec[lat_done_rd] = 1'b1;
        end
    end

    // Set wins over clear so a same-edge done/issue on one rd leaves it pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= ((pend_q & ~clr_vec) | set_vec) & WRITABLE;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select, load-use / scoreboard hazard detection and stall watchdog.
// Optional statistics counters are enabled with the FWD_HAZARD_STATS_EN macro.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int NUM_SRC       = 2,
    parameter int NUM_FWD       = 2,
    parameter int STALL_TIMEOUT = 64
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [NUM_SRC-1:0]                         src_valid,
    input  logic [NUM_SRC-1:0][REG_IDX_W-1:0]          src_rs,
    input  logic [NUM_FWD-1:0]                         fwd_we,
    input  logic [NUM_FWD-1:0][REG_IDX_W-1:0]          fwd_rd,
    input  logic [NUM_FWD-1:0]                         fwd_rdy,
    input  logic                                       lat_issue,
    input  logic [REG_IDX_W-1:0]                       lat_rd,
    input  logic                                       lat_done,
    input  logic [REG_IDX_W-1:0]                       lat_done_rd,
    output logic [NUM_SRC-1:0][fwd_sel_w(NUM_FWD)-1:0] fwd_sel,
    output logic                                       stall,
    output logic                                       issue_stall,
    output logic                                       stall_timeout
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [31:0]                                stat_stall_cnt,
    output logic [31:0]                                stat_fwd_cnt
`endif
);

    localparam int SEL_W = fwd_sel_w(NUM_FWD);
    localparam int CNT_W = $clog2(STALL_TIMEOUT + 1);

    logic [NUM_ARCH_REGS-1:0] pending;
    logic [NUM_SRC-1:0]       sel_rdy;
    logic [NUM_SRC-1:0]       load_use;
    logic [NUM_SRC-1:0]       sb_haz;
    logic [CNT_W-1:0]         stall_cnt;

    fwd_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .lat_issue   (lat_issue),
        .lat_rd      (lat_rd),
        .lat_done    (lat_done),
        .lat_done_rd (lat_done_rd),
        .pending     (pending),
        .issue_stall (issue_stall)
    );

    // Scan oldest to youngest so the youngest matching stage is the last write.
    always_comb begin
        fwd_sel = '0;
        sel_rdy = '1;
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int j = NUM_FWD - 1; j >= 0; j--) begin
                if (src_valid[k] && (src_rs[k] != '0) && fwd_we[j] &&
                    (fwd_rd[j] == src_rs[k])) begin
                    fwd_sel[k] = SEL_W'(j + 1);
                    sel_rdy[k] = fwd_rdy[j];
                end
            end
        end
    end

    // A ready forwarding match supersedes a pending scoreboard entry.
    always_comb begin
        load_use = '0;
        sb_haz   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            load_use[k] = (fwd_sel[k] != '0) && !sel_rdy[k];
            sb_haz[k]   = src_valid[k] && (fwd_sel[k] == '0) && pending[src_rs[k]];
        end
    end

    assign stall = (|load_use) || (|sb_haz);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt     <= '0;
            stall_timeout <= 1'b0;
        end else begin
            if (!stall) begin
                stall_cnt <= '0;
            end else if (stall_cnt != CNT_W'(STALL_TIMEOUT)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (stall_cnt == CNT_W'(STALL_TIMEOUT)) begin
                stall_timeout <= 1'b1;
            end
        end
    end

`ifdef FWD_HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall_cnt <= '0;
            stat_fwd_cnt   <= '0;
        end else begin
            if (stall && (stat_stall_cnt != '1)) begin
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
            end
            if (!stall && (|fwd_sel) && (stat_fwd_cnt != '1)) begin
                stat_fwd_cnt <= stat_fwd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: vector table, directed sequences, random vs. model.
module tb_fwd_hazard_unit;

    localparam int TIMEOUT = 64;

    logic            clk;
    logic            rst;
    logic [1:0]      src_valid;
    logic [1:0][4:0] src_rs;
    logic [1:0]      fwd_we;
    logic [1:0][4:0] fwd_rd;
    logic [1:0]      fwd_rdy;
    logic            lat_issue;
    logic [4:0]      lat_rd;
    logic            lat_done;
    logic [4:0]      lat_done_rd;
    logic [1:0][1:0] fwd_sel;
    logic            stall;
    logic            issue_stall;
    logic            stall_timeout;
`ifdef FWD_HAZARD_STATS_EN
    logic [31:0]     stat_stall_cnt;
    logic [31:0]     stat_fwd_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [6:0] exp_q[$];

    fwd_hazard_unit #(.NUM_SRC(2), .NUM_FWD(2), .STALL_TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .src_valid     (src_valid),
        .src_rs        (src_rs),
        .fwd_we        (fwd_we),
        .fwd_rd        (fwd_rd),
        .fwd_rdy       (fwd_rdy),
        .lat_issue     (lat_issue),
        .lat_rd        (lat_rd),
        .lat_done      (lat_done),
        .lat_done_rd   (lat_done_rd),
        .fwd_sel       (fwd_sel),
        .stall         (stall),
        .issue_stall   (issue_stall),
        .stall_timeout (stall_timeout)
`ifdef FWD_HAZARD_STATS_EN
        ,
        .stat_stall_cnt(stat_stall_cnt),
        .stat_fwd_cnt  (stat_fwd_cnt)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    typedef struct {
        string      name;
        logic [1:0] sv;
        logic [4:0] rs0, rs1;
        logic [1:0] we;
        logic [4:0] rd0, rd1;
        logic [1:0] rdy;
        logic [1:0] sel0, sel1;
        logic       stl;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        src_valid   = '0;
        src_rs      = '0;
        fwd_we      = '0;
        fwd_rd      = '0;
        fwd_rdy     = '1;
        lat_issue   = 1'b0;
        lat_rd      = '0;
        lat_done    = 1'b0;
        lat_done_rd = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic issue_lat(input logic [4:0] rd);
        lat_issue = 1'b1;
        lat_rd    = rd;
        tick();
        lat_issue = 1'b0;
        lat_rd    = '0;
    endtask

    task automatic use_src0(input logic [4:0] rs);
        src_valid = 2'b01;
        src_rs[0] = rs;
    endtask

    // Reference model state: set of pending registers and stall streak.
    bit pend_set[32];
    int streak;
    bit timeout_flag;

    function automatic logic [1:0] ref_sel(input logic v, input logic [4:0] rs);
        if (!v || rs == 0) return 2'd0;
        for (int j = 0; j < 2; j++)
            if (fwd_we[j] && fwd_rd[j] == rs) return 2'(j + 1);
        return 2'd0;
    endfunction

    function automatic bit ref_hazard(input logic v, input logic [4:0] rs, input logic [1:0] s);
        if (!v) return 1'b0;
        if (s != 0) return !fwd_rdy[s-1];
        return pend_set[rs];
    endfunction

    initial begin
        rst = 1'b1;
        drive_idle();
        vecs[0] = '{"fwd_basic",   2'b01, 5'd5,  5'd0,  2'b11, 5'd5,  5'd5,  2'b11, 2'd1, 2'd0, 1'b0};
        vecs[1] = '{"fwd_stage1",  2'b11, 5'd3,  5'd4,  2'b10, 5'd4,  5'd3,  2'b11, 2'd2, 2'd0, 1'b0};
        vecs[2] = '{"load_use",    2'b10, 5'd0,  5'd7,  2'b01, 5'd7,  5'd0,  2'b10, 2'd0, 2'd1, 1'b1};
        vecs[3] = '{"youngest",    2'b01, 5'd8,  5'd0,  2'b11, 5'd8,  5'd8,  2'b01, 2'd1, 2'd0, 1'b0};
        vecs[4] = '{"zero_reg",    2'b11, 5'd0,  5'd0,  2'b11, 5'd0,  5'd0,  2'b00, 2'd0, 2'd0, 1'b0};
        vecs[5] = '{"invalid",     2'b00, 5'd6,  5'd6,  2'b11, 5'd6,  5'd6,  2'b00, 2'd0, 2'd0, 1'b0};
        vecs[6] = '{"two_ports",   2'b11, 5'd10, 5'd11, 2'b11, 5'd11, 5'd10, 2'b11, 2'd2, 2'd1, 1'b0};
        vecs[7] = '{"stage1_load", 2'b01, 5'd12, 5'd0,  2'b10, 5'd0,  5'd12, 2'b01, 2'd2, 2'd0, 1'b1};

        do_reset();
        check("rst_stall", stall, 0);
        check("rst_issue_stall", issue_stall, 0);
        check("rst_timeout", stall_timeout, 0);
        check("rst_sel", fwd_sel, 0);

        // Combinational vector table
        for (int i = 0; i < 8; i++) begin
            src_valid = vecs[i].sv;
            src_rs[0] = vecs[i].rs0;
            src_rs[1] = vecs[i].rs1;
            fwd_we    = vecs[i].we;
            fwd_rd[0] = vecs[i].rd0;
            fwd_rd[1] = vecs[i].rd1;
            fwd_rdy   = vecs[i].rdy;
            #1;
            check({vecs[i].name, "_sel0"}, fwd_sel[0], vecs[i].sel0);
            check({vecs[i].name, "_sel1"}, fwd_sel[1], vecs[i].sel1);
            check({vecs[i].name, "_stall"}, stall, vecs[i].stl);
            tick();
        end

        // Load-use resolves when stage 0 becomes ready
        drive_idle();
        src_valid = 2'b10; src_rs[1] = 5'd7; fwd_we = 2'b01; fwd_rd[0] = 5'd7; fwd_rdy = 2'b00;
        #1;
        check("lu_sel", fwd_sel[1], 1);
        check("lu_stall", stall, 1);
        tick();
        fwd_rdy = 2'b01;
        #1;
        check("lu_resolved_stall", stall, 0);
        check("lu_resolved_sel", fwd_sel[1], 1);
        tick();

        // Scoreboard hazard until the cycle after lat_done
        do_reset();
        issue_lat(5'd9);
        use_src0(5'd9);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("sb_stall_hold", stall, 1);
            tick();
        end
        lat_done = 1'b1; lat_done_rd = 5'd9;
        #1;
        check("sb_stall_done_cycle", stall, 1);
        tick();
        lat_done = 1'b0;
        #1;
        check("sb_stall_cleared", stall, 0);

        // Ready forwarding match overrides a pending entry
        drive_idle();
        issue_lat(5'd13);
        use_src0(5'd13); fwd_we = 2'b10; fwd_rd[1] = 5'd13; fwd_rdy = 2'b11;
        #1;
        check("sb_fwd_override_stall", stall, 0);
        check("sb_fwd_override_sel", fwd_sel[0], 2);

        // WAW blocking on a pending rd
        do_reset();
        issue_lat(5'd9);
        lat_issue = 1'b1; lat_rd = 5'd9;
        #1;
        check("waw_issue_stall", issue_stall, 1);
        tick();
        lat_issue = 1'b1; lat_rd = 5'd9; lat_done = 1'b1; lat_done_rd = 5'd9;
        #1;
        check("waw_same_done_issue_stall", issue_stall, 0);
        tick();
        drive_idle();
        use_src0(5'd9);
        #1;
        check("waw_still_pending", stall, 1);
        lat_done = 1'b1; lat_done_rd = 5'd9;
        tick();
        lat_done = 1'b0;
        #1;
        check("waw_released", stall, 0);

        // Stall watchdog
        do_reset();
        issue_lat(5'd9);
        use_src0(5'd9);
        for (int n = 0; n < 66; n++) begin
            if (n == 63) check("timeout_early", stall_timeout, 0);
            tick();
        end
        check("timeout_set", stall_timeout, 1);
        drive_idle();
        tick();
        tick();
        check("timeout_sticky", stall_timeout, 1);

        // Reset mid-operation discards pending; a late lat_done is harmless
        do_reset();
        check("timeout_cleared", stall_timeout, 0);
        use_src0(5'd9);
        #1;
        check("rst_discards_pending", stall, 0);
        lat_done = 1'b1; lat_done_rd = 5'd9;
        tick();
        lat_done = 1'b0;
        #1;
        check("late_done_harmless", stall, 0);

        // Random stimulus against the reference model
        do_reset();
        for (int r = 0; r < 32; r++) pend_set[r] = 1'b0;
        streak = 0;
        timeout_flag = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [1:0] es0, es1;
            bit         est, eis, blocked;
            logic [6:0] exp_v, got_v;
            src_valid   = 2'($urandom_range(0, 3));
            src_rs[0]   = 5'($urandom_range(0, 7));
            src_rs[1]   = 5'($urandom_range(0, 7));
            fwd_we      = 2'($urandom_range(0, 3));
            fwd_rd[0]   = 5'($urandom_range(0, 7));
            fwd_rd[1]   = 5'($urandom_range(0, 7));
            fwd_rdy     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            lat_issue   = ($urandom_range(0, 3) == 0);
            lat_rd      = 5'($urandom_range(0, 7));
            lat_done    = ($urandom_range(0, 2) == 0);
            lat_done_rd = 5'($urandom_range(0, 7));
            #1;
            es0 = ref_sel(src_valid[0], src_rs[0]);
            es1 = ref_sel(src_valid[1], src_rs[1]);
            est = ref_hazard(src_valid[0], src_rs[0], es0) ||
                  ref_hazard(src_valid[1], src_rs[1], es1);
            blocked = lat_issue && pend_set[lat_rd] && !(lat_done && lat_done_rd == lat_rd);
            eis = blocked;
            exp_q.push_back({es1, es0, est, eis, timeout_flag});
            got_v = {fwd_sel[1], fwd_sel[0], stall, issue_stall, stall_timeout};
            exp_v = exp_q.pop_front();
            check($sformatf("rand_c%0d", cyc), got_v, exp_v);
            // advance model to the next edge
            if (streak == TIMEOUT) timeout_flag = 1'b1;
            streak = est ? ((streak < TIMEOUT) ? streak + 1 : TIMEOUT) : 0;
            if (lat_done) pend_set[lat_done_rd] = 1'b0;
            if (lat_issue && !blocked && lat_rd != 0) pend_set[lat_rd] = 1'b1;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
